// File: rtl/router_rx_if.sv
// Handshake and bus bundle between the router receive controller and its FIFOs, decap engine and arbiter.
// The master modport is the controller side; the slave modport is the surrounding datapath.
interface router_rx_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  rx_enable;
  logic                  empty_output_port_0;
  logic                  rd_output_port_0;
  logic                  start_decap_pkt;
  logic                  decap_done;
  logic [8:0]            header_pkt_recv;
  logic [ADDR_WIDTH-1:0] dst_addr_arbiter_recv;
  logic                  arbiter_write_req;
  logic                  arbiter_write_gnt;
  logic [ADDR_WIDTH-1:0] arbiter_dst_addr;
  logic                  we_output_port_0;
  logic                  we_output_port_1;
  logic                  full_output_port_1;
  logic [8:0]            header_fwd_o;
  logic [1:0]            control_crossbar;
  logic                  rx_done;
  logic                  rx_drop;

  modport master (
    input  rx_enable,
    input  empty_output_port_0,
    output rd_output_port_0,
    output start_decap_pkt,
    input  decap_done,
    input  header_pkt_recv,
    input  dst_addr_arbiter_recv,
    output arbiter_write_req,
    input  arbiter_write_gnt,
    output arbiter_dst_addr,
    output we_output_port_0,
    output we_output_port_1,
    input  full_output_port_1,
    output header_fwd_o,
    output control_crossbar,
    output rx_done,
    output rx_drop
  );

  modport slave (
    output rx_enable,
    output empty_output_port_0,
    input  rd_output_port_0,
    input  start_decap_pkt,
    output decap_done,
    output header_pkt_recv,
    output dst_addr_arbiter_recv,
    input  arbiter_write_req,
    output arbiter_write_gnt,
    input  arbiter_dst_addr,
    input  we_output_port_0,
    input  we_output_port_1,
    output full_output_port_1,
    input  header_fwd_o,
    input  control_crossbar,
    input  rx_done,
    input  rx_drop
  );
endinterface

// File: rtl/router_rx_controller.sv
// Receive-side packet controller: starts decap, classifies by destination/TTL and steers each
// payload beat to local memory, the forward port, or the bit bucket.
module router_rx_controller #(
  parameter int unsigned                     AURORA_DATA_WIDTH      = 64,
  parameter int unsigned                     ADDR_WIDTH             = 10,
  parameter int unsigned                     NUMBER_PACKET          = 19,
  parameter int unsigned                     RECOGNIZE_ROUTER_WIDTH = 2,
  parameter logic [RECOGNIZE_ROUTER_WIDTH-1:0] ROUTER_ID            = '0
) (
  input  logic          clk,
  input  logic          rst,
  router_rx_if.master   bus
);

  localparam int unsigned CNT_W     = (NUMBER_PACKET > 1) ? $clog2(NUMBER_PACKET) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUMBER_PACKET - 1);

  localparam logic [1:0] XBAR_IDLE  = 2'b00;
  localparam logic [1:0] XBAR_LOCAL = 2'b01;
  localparam logic [1:0] XBAR_FWD   = 2'b10;
  localparam logic [1:0] XBAR_DROP  = 2'b11;

  // Payload beats are carried outside this block; only a degenerate width is rejected here.
  if (AURORA_DATA_WIDTH == 0 || NUMBER_PACKET == 0) begin : g_bad_cfg
    $error("router_rx_controller: AURORA_DATA_WIDTH and NUMBER_PACKET must be non-zero");
  end

  typedef struct packed {
    logic [1:0] ttl;
    logic [1:0] dst;
    logic [1:0] src;
    logic [2:0] rsvd;
  } hdr_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START_DECAP,
    S_WAIT_DECAP,
    S_CLASSIFY,
    S_WRITE_ARB,
    S_XFER_LOCAL,
    S_XFER_FWD,
    S_XFER_DROP,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      beat_q, beat_d;
  hdr_t                  hdr_q, hdr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [8:0]            hdr_fwd_q, hdr_fwd_d;
  logic [1:0]            xbar_q, xbar_d;
  logic                  start_q, start_d;
  logic                  req_q, req_d;
  logic                  done_q, done_d;
  logic                  drop_q, drop_d;

  logic                  xfer_c;
  logic                  rd_c;
  logic                  we0_c;
  logic                  we1_c;
  logic [1:0]            ttl_dec_c;

  assign ttl_dec_c = hdr_q.ttl - 2'd1;

  // Next-state, datapath latches and same-cycle transfer strobes.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    hdr_d     = hdr_q;
    addr_d    = addr_q;
    hdr_fwd_d = hdr_fwd_q;
    xbar_d    = xbar_q;
    start_d   = 1'b0;
    req_d     = 1'b0;
    done_d    = 1'b0;
    drop_d    = 1'b0;
    xfer_c    = 1'b0;
    rd_c      = 1'b0;
    we0_c     = 1'b0;
    we1_c     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.rx_enable && !bus.empty_output_port_0) state_d = S_START_DECAP;
      end
      S_START_DECAP: state_d = S_WAIT_DECAP;
      S_WAIT_DECAP: begin
        if (bus.decap_done) begin
          hdr_d   = hdr_t'(bus.header_pkt_recv);
          addr_d  = bus.dst_addr_arbiter_recv;
          state_d = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        // Local delivery wins even when TTL has expired.
        if (hdr_q.dst == 2'(ROUTER_ID)) begin
          state_d = S_WRITE_ARB;
        end else if (hdr_q.ttl == 2'd0) begin
          state_d = S_XFER_DROP;
        end else begin
          state_d   = S_XFER_FWD;
          hdr_fwd_d = {ttl_dec_c, hdr_q.dst, hdr_q.src, hdr_q.rsvd};
        end
      end
      S_WRITE_ARB: begin
        if (bus.arbiter_write_gnt) state_d = S_XFER_LOCAL;
      end
      S_XFER_LOCAL: begin
        xfer_c = !bus.empty_output_port_0;
        rd_c   = xfer_c;
        we0_c  = xfer_c;
      end
      S_XFER_FWD: begin
        xfer_c = !bus.empty_output_port_0 && !bus.full_output_port_1;
        rd_c   = xfer_c;
        we1_c  = xfer_c;
      end
      S_XFER_DROP: begin
        xfer_c = !bus.empty_output_port_0;
        rd_c   = xfer_c;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (xfer_c) begin
      if (beat_q == LAST_BEAT) begin
        beat_d  = '0;
        state_d = S_DONE;
      end else begin
        beat_d = beat_q + CNT_W'(1);
      end
    end

    // Registered outputs are decoded from the state being entered.
    start_d = (state_d == S_START_DECAP);
    req_d   = (state_d == S_WRITE_ARB);
    done_d  = (state_d == S_DONE) && (state_q == S_XFER_LOCAL || state_q == S_XFER_FWD);
    drop_d  = (state_d == S_DONE) && (state_q == S_XFER_DROP);

    unique case (state_d)
      S_XFER_LOCAL:   xbar_d = XBAR_LOCAL;
      S_XFER_FWD:     xbar_d = XBAR_FWD;
      S_XFER_DROP:    xbar_d = XBAR_DROP;
      S_IDLE, S_DONE: xbar_d = XBAR_IDLE;
      default:        xbar_d = xbar_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      hdr_q     <= '0;
      addr_q    <= '0;
      hdr_fwd_q <= '0;
      xbar_q    <= XBAR_IDLE;
      start_q   <= 1'b0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      hdr_q     <= hdr_d;
      addr_q    <= addr_d;
      hdr_fwd_q <= hdr_fwd_d;
      xbar_q    <= xbar_d;
      start_q   <= start_d;
      req_q     <= req_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.rd_output_port_0  = rd_c;
  assign bus.we_output_port_0  = we0_c;
  assign bus.we_output_port_1  = we1_c;
  assign bus.start_decap_pkt   = start_q;
  assign bus.arbiter_write_req = req_q;
  assign bus.arbiter_dst_addr  = addr_q;
  assign bus.header_fwd_o      = hdr_fwd_q;
  assign bus.control_crossbar  = xbar_q;
  assign bus.rx_done           = done_q;
  assign bus.rx_drop           = drop_q;

endmodule

// File: doc/router_rx_controller.md
# router_rx_controller

Receive-side controller of the router, the counterpart of the transmit/encode controller. It watches the output-port-0 receive FIFO and starts packet decapsulation. It then classifies the packet by destination router and TTL, and routes it one of three ways: local memory (via an arbiter write grant), forward to output port 1, or drop. It drives the crossbar select and the FIFO pop/write strobes for every payload beat.

## Interface
- AURORA_DATA_WIDTH, 64, payload beat width (passes through externally; sizes nothing here)
- ADDR_WIDTH, 10, memory address width
- NUMBER_PACKET, 19, payload beats per packet
- RECOGNIZE_ROUTER_WIDTH, 2, router ID width
- ROUTER_ID, 2'b00, this router's ID

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx_enable  in  1  permits starting a new packet
- empty_output_port_0  in  1  receive FIFO empty (first-word-fall-through)
- rd_output_port_0  out  1  pop receive FIFO
- start_decap_pkt  out  1  one-cycle decap start pulse
- decap_done  in  1  decap finished; header/address valid this cycle
- header_pkt_recv  in  9  [8:7] TTL, [6:5] dst router, [4:3] src router, [2:0] reserved
- dst_addr_arbiter_recv  in  ADDR_WIDTH  destination memory address
- arbiter_write_req  out  1  memory write request
- arbiter_write_gnt  in  1  memory write grant
- arbiter_dst_addr  out  ADDR_WIDTH  latched destination address
- we_output_port_0  out  1  local-delivery write strobe
- we_output_port_1  out  1  forward write strobe
- full_output_port_1  in  1  forward FIFO full
- header_fwd_o  out  9  forwarded header, TTL decremented
- control_crossbar  out  2  00 idle, 01 local, 10 forward, 11 drop
- rx_done  out  1  one-cycle pulse, packet delivered or forwarded
- rx_drop  out  1  one-cycle pulse, packet dropped

## Operation
States: IDLE, START_DECAP, WAIT_DECAP, CLASSIFY, WRITE_ARB, XFER_LOCAL, XFER_FWD, XFER_DROP, DONE.
- IDLE -> START_DECAP when rx_enable && !empty_output_port_0.
- START_DECAP: start_decap_pkt = 1 for exactly this cycle; -> WAIT_DECAP.
- WAIT_DECAP: on decap_done, latch header_pkt_recv and dst_addr_arbiter_recv; -> CLASSIFY. Otherwise stay.
- CLASSIFY, priority order:
  - dst == ROUTER_ID -> WRITE_ARB (local delivery takes precedence even when TTL == 0).
  - else TTL == 0 -> XFER_DROP.
  - else -> XFER_FWD, and header_fwd_o <= {TTL-1, header[6:0]}.
- WRITE_ARB: arbiter_write_req = 1 and arbiter_dst_addr = latched address, held until arbiter_write_gnt; -> XFER_LOCAL on the gnt cycle.
- Beat counter runs 0..NUMBER_PACKET-1 and increments only on a transferred beat. A transfer occurs, combinationally in the same cycle:
  - XFER_LOCAL: rd_output_port_0 = we_output_port_0 = !empty_output_port_0.
  - XFER_FWD: rd_output_port_0 = we_output_port_1 = !empty_output_port_0 && !full_output_port_1.
  - XFER_DROP: rd_output_port_0 = !empty_output_port_0; no write strobe.
- The transfer of beat NUMBER_PACKET-1 -> DONE; counter clears.
- DONE: rx_done = 1 for a local or forwarded packet, rx_drop = 1 for a dropped one, for this cycle only; -> IDLE.
- control_crossbar is registered on entry to each XFER state, set to 00 in DONE and IDLE, and stable for the whole transfer.
- rx_enable is sampled only in IDLE; deasserting it mid-packet does not abort the packet.
- No decap timeout: WAIT_DECAP waits indefinitely.

## Timing
- Reset values:
  - all strobes and pulses 0
  - control_crossbar = 00
  - header_fwd_o = 0, arbiter_dst_addr = 0
  - beat counter 0, state IDLE
- Reset asserted mid-packet returns to IDLE next edge; no partial completion pulse.
- start_decap_pkt rises 1 cycle after the IDLE condition is sampled true.
- CLASSIFY always lasts exactly 1 cycle.
- The arbiter request is visible the cycle after CLASSIFY; the first local beat can transfer the cycle after the gnt.
- With no stalls, a local packet takes NUMBER_PACKET transfer cycles; each empty or full stall cycle adds one cycle.
- The transfer cycle of beat NUMBER_PACKET-1 is followed by exactly one DONE cycle, then IDLE.
- Back-to-back packets: the earliest next start_decap_pkt is 2 cycles after DONE.

## Test plan
- Local packet, header 9'b11_00_01_000, address 10'h155, FIFO never empty -> one start_decap_pkt pulse; arbiter_dst_addr = 10'h155; after gnt, 19 consecutive cycles of rd = we_output_port_0 = 1 with control_crossbar = 01; one rx_done pulse.
- Forward, header 9'b10_01_00_000 -> header_fwd_o = 9'b01_01_00_000, control_crossbar = 10, 19 we_output_port_1 strobes; full_output_port_1 held high for 3 cycles mid-stream -> rd and we both 0 for those 3 cycles, transfer stretches by 3 cycles.
- Drop, header 9'b00_10_00_000 -> 19 pops, no we_output_port_0 or we_output_port_1, control_crossbar = 11, one rx_drop pulse, no arbiter request.
- Grant delayed 5 cycles and FIFO empty on beat 7 -> request held 5 cycles; no pop while empty; exactly 19 beats counted.
- rst asserted during beat 10 of a forward -> next cycle all outputs at reset values, state IDLE, no rx_done; the next packet completes normally.
- rx_enable = 0 with FIFO non-empty -> no start_decap_pkt; raising rx_enable starts the packet 1 cycle later.
